// File: rtl/ct_spsram_256x54_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM request controller.
package ct_spsram_256x54_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int RSP_DEPTH = 2;
  localparam int RSP_PTR_W = $clog2(RSP_DEPTH);
  localparam int RSP_CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int OCC_W     = RSP_CNT_W + 1;

  localparam logic [53:0] INIT_VALUE_DEF = 54'b0;

endpackage

// File: rtl/ct_spsram_256x54_ctrl_rsp_fifo.sv
// Two-entry synchronous response FIFO; head is presented combinationally.
// Push into a full FIFO is only honoured when a pop happens in the same cycle.
module ct_spsram_rsp_fifo
  import ct_spsram_256x54_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 54
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_dat,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_dat,
  output logic                  full,
  output logic                  empty,
  output logic [RSP_CNT_W-1:0]  count
);

  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];
  logic [RSP_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [RSP_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [RSP_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full     = (cnt_q == RSP_CNT_W'(RSP_DEPTH));
    empty    = (cnt_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + RSP_CNT_W'(do_push) - RSP_CNT_W'(do_pop);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = cnt_q;

endmodule

// File: rtl/ct_spsram_256x54_ctrl.sv
// Valid/ready front end for the 256x54 single-port SRAM: strobe muxing, 2-deep read response
// buffering with backpressure, and an optional post-reset zero sweep (CT_SPSRAM_CTRL_INIT_EN).
module ct_spsram_256x54_ctrl
  import ct_spsram_256x54_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 54,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = INIT_VALUE_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  state_e                state_q, state_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic                  accept;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [RSP_CNT_W-1:0]  fifo_cnt;
  logic [OCC_W-1:0]      occ;
`ifdef CT_SPSRAM_CTRL_INIT_EN
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    rd_inflight_d = 1'b0;
    sram_cen      = 1'b1;
    sram_gwen     = 1'b1;
    sram_wen      = '1;
    sram_a        = '0;
    sram_d        = '0;
`ifdef CT_SPSRAM_CTRL_INIT_EN
    init_cnt_d    = init_cnt_q;
`endif
    fifo_pop  = rsp_vld && rsp_rdy;
    // Count reads that still need a FIFO slot, crediting a pop happening this cycle.
    occ       = OCC_W'(fifo_cnt) + OCC_W'(rd_inflight_q) - OCC_W'(fifo_pop);
    req_rdy   = (state_q == ST_RUN) && !RST && (occ < OCC_W'(RSP_DEPTH));
    init_done = (state_q == ST_RUN) && !RST;
    accept    = req_vld && req_rdy;

    case (state_q)
      ST_INIT: begin
        if (!RST) begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = '0;
          sram_d    = INIT_VALUE;
        end
`ifdef CT_SPSRAM_CTRL_INIT_EN
        sram_a     = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = ST_RUN;
        end
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        if (accept) begin
          sram_cen = 1'b0;
          sram_a   = req_addr;
          if (req_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~req_wmask;
            sram_d    = req_wdata;
          end else begin
            rd_inflight_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
`ifdef CT_SPSRAM_CTRL_INIT_EN
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
`else
      state_q    <= ST_RUN;
`endif
      rd_inflight_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_inflight_q <= rd_inflight_d;
`ifdef CT_SPSRAM_CTRL_INIT_EN
      init_cnt_q    <= init_cnt_d;
`endif
    end
  end

  ct_spsram_rsp_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rsp_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (rd_inflight_q),
    .push_dat(sram_q),
    .pop     (fifo_pop),
    .pop_dat (rsp_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign rsp_vld = !fifo_empty;

  // The ready logic must never let a read land in a full FIFO that is not draining.
  a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
    !(fifo_full && rd_inflight_q && !fifo_pop));

endmodule
